// File: rtl/reg_file_param_if.sv
// Bus between the register file and its control/datapath users.
// Carries read addresses/data, write port, sweep request and status.
interface reg_file_param_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [WIDTH-1:0]  C;
    logic [ADDR_W-1:0] Aaddr;
    logic [ADDR_W-1:0] Baddr;
    logic [ADDR_W-1:0] Caddr;
    logic              Load;
    logic              Sweep;
    logic              Busy;
    logic              LoadAck;

    // Control unit / datapath side
    modport master (
        output C, Aaddr, Baddr, Caddr, Load, Sweep,
        input  A, B, Busy, LoadAck
    );

    // Register file side
    modport slave (
        input  C, Aaddr, Baddr, Caddr, Load, Sweep,
        output A, B, Busy, LoadAck
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports (A, B), one
// synchronous write port (C), and a soft-clear sweep that zeroes one
// register per cycle while Busy is high.
// Optional macro REGFILE_BYPASS_EN: forward write data to a read port whose
// address matches an accepted write in the same cycle.
module reg_file_param #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic            Clk,
    input  logic            Clear,
    reg_file_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              busy_q;
    logic              ack_q;
    logic              wr_en;

    // A write lands only while idle, and never into a hardwired-zero r0
    assign wr_en = (state == IDLE) && bus.Load &&
                   !((ZERO_REG != 0) && (bus.Caddr == '0));

    assign bus.Busy    = busy_q;
    assign bus.LoadAck = ack_q;

    // Register array, sweep sequencer and registered status outputs
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= wr_en;
            if (wr_en) begin
                regs[bus.Caddr] <= bus.C;
            end
            case (state)
                IDLE: begin
                    if (bus.Sweep) begin
                        state  <= SWEEP;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    regs[cnt] <= '0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read port A: array lookup, optional forwarding, hardwired-zero r0 last
    always_comb begin
        bus.A = regs[bus.Aaddr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.Aaddr == bus.Caddr)) begin
            bus.A = bus.C;
        end
`endif
        if ((ZERO_REG != 0) && (bus.Aaddr == '0)) begin
            bus.A = '0;
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        bus.B = regs[bus.Baddr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.Baddr == bus.Caddr)) begin
            bus.B = bus.C;
        end
`endif
        if ((ZERO_REG != 0) && (bus.Baddr == '0)) begin
            bus.B = '0;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default 16x16 file, a ZERO_REG
// variant and a 32x32 variant, all sharing clock and Clear.
module tb_reg_file_param;
    logic Clk = 1'b0;
    logic Clear;

    always #5 Clk = ~Clk;

    reg_file_param_if #(.WIDTH(16), .ADDR_W(4)) bm ();
    reg_file_param_if #(.WIDTH(16), .ADDR_W(4)) bz ();
    reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) bw ();

    reg_file_param #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0)) u_main (.Clk(Clk), .Clear(Clear), .bus(bm));
    reg_file_param #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) u_zero (.Clk(Clk), .Clear(Clear), .bus(bz));
    reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) u_wide (.Clk(Clk), .Clear(Clear), .bus(bw));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [15:0] mem [16];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        bm.C = '0; bm.Aaddr = '0; bm.Baddr = '0; bm.Caddr = '0; bm.Load = 0; bm.Sweep = 0;
        bz.C = '0; bz.Aaddr = '0; bz.Baddr = '0; bz.Caddr = '0; bz.Load = 0; bz.Sweep = 0;
        bw.C = '0; bw.Aaddr = '0; bw.Baddr = '0; bw.Caddr = '0; bw.Load = 0; bw.Sweep = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        Clear = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #12;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", bm.A, e); end
        e = exp_q.pop_front(); total++;
        if (32'(bm.B) !== e) begin bad++; $display("FAIL reset_b got=%h exp=%h", bm.B, e); end
        total++;
        if (bm.Busy !== 1'b0 || bm.LoadAck !== 1'b0) begin
            bad++; $display("FAIL reset_status got busy=%b ack=%b exp busy=0 ack=0", bm.Busy, bm.LoadAck);
        end
        Clear = 1'b0;
        tick();
        bm.Load = 1; bm.Caddr = 4'd5; bm.C = 16'h1234; bm.Aaddr = 4'd5;
        tick();
        bm.Load = 0;
        exp_q.push_back(32'h1234);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL reset_prewrite got=%h exp=%h", bm.A, e); end
        #2 Clear = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL reset_async_a got=%h exp=%h", bm.A, e); end
        total++;
        if (bm.Busy !== 1'b0 || bm.LoadAck !== 1'b0) begin
            bad++; $display("FAIL reset_async_status got busy=%b ack=%b exp busy=0 ack=0", bm.Busy, bm.LoadAck);
        end
        #1 Clear = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        bm.Load = 1; bm.Caddr = 4'd3; bm.C = 16'hBEEF; bm.Aaddr = 4'd0; bm.Baddr = 4'd0;
        tick();
        mem[3] = 16'hBEEF;
        bm.Load = 0; bm.Aaddr = 4'd3; bm.Baddr = 4'd3;
        exp_q.push_back(32'(mem[3])); exp_q.push_back(32'(mem[3]));
        #1;
        total++;
        if (bm.LoadAck !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", bm.LoadAck); end
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL wr_read_a got=%h exp=%h", bm.A, e); end
        e = exp_q.pop_front(); total++;
        if (32'(bm.B) !== e) begin bad++; $display("FAIL wr_read_b got=%h exp=%h", bm.B, e); end
        tick();
        total++;
        if (bm.LoadAck !== 1'b0) begin bad++; $display("FAIL wr_ack_drop got=%b exp=0", bm.LoadAck); end
        // back-to-back writes keep LoadAck high every cycle
        for (int i = 10; i < 13; i++) begin
            bm.Load = 1; bm.Caddr = 4'(i); bm.C = 16'(16'hA000 + i);
            mem[i] = 16'(16'hA000 + i);
            tick();
            total++;
            if (bm.LoadAck !== 1'b1) begin bad++; $display("FAIL b2b_ack got=%b exp=1", bm.LoadAck); end
        end
        bm.Load = 0;
        for (int i = 10; i < 13; i++) begin
            bm.Aaddr = 4'(i);
            exp_q.push_back(32'(mem[i]));
            #1;
            e = exp_q.pop_front(); total++;
            if (32'(bm.A) !== e) begin bad++; $display("FAIL b2b_read got=%h exp=%h", bm.A, e); end
        end
        tick();
    endtask

    task automatic test_sweep;
        int busy_cnt;
        for (int i = 0; i < 16; i++) begin
            bm.Load = 1; bm.Caddr = 4'(i); bm.C = 16'(16'h0101 * i);
            mem[i] = 16'(16'h0101 * i);
            tick();
        end
        bm.Load = 0;
        for (int i = 0; i < 16; i++) begin
            bm.Aaddr = 4'(i); bm.Baddr = 4'(15 - i);
            exp_q.push_back(32'(mem[i])); exp_q.push_back(32'(mem[15 - i]));
            #1;
            e = exp_q.pop_front(); total++;
            if (32'(bm.A) !== e) begin bad++; $display("FAIL fill_a got=%h exp=%h", bm.A, e); end
            e = exp_q.pop_front(); total++;
            if (32'(bm.B) !== e) begin bad++; $display("FAIL fill_b got=%h exp=%h", bm.B, e); end
        end
        // Sweep with a coincident Load: that write is accepted
        bm.Sweep = 1; bm.Load = 1; bm.Caddr = 4'd2; bm.C = 16'h7777;
        tick();
        mem[2] = 16'h7777;
        total++;
        if (bm.LoadAck !== 1'b1 || bm.Busy !== 1'b1) begin
            bad++; $display("FAIL sweep_start got ack=%b busy=%b exp ack=1 busy=1", bm.LoadAck, bm.Busy);
        end
        busy_cnt = 1;
        // Sweep held high and a Load while sweeping: both must be ignored
        bm.Caddr = 4'd7; bm.C = 16'hAAAA;
        tick();
        total++;
        if (bm.LoadAck !== 1'b0) begin bad++; $display("FAIL sweep_load_ack got=%b exp=0", bm.LoadAck); end
        bm.Load = 0; bm.Aaddr = 4'd0; bm.Baddr = 4'd15;
        mem[0] = '0;
        exp_q.push_back(32'(mem[0])); exp_q.push_back(32'(mem[15]));
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL sweep_mid_r0 got=%h exp=%h", bm.A, e); end
        e = exp_q.pop_front(); total++;
        if (32'(bm.B) !== e) begin bad++; $display("FAIL sweep_mid_r15 got=%h exp=%h", bm.B, e); end
        tick();
        busy_cnt++;
        bm.Sweep = 0;
        for (int k = 0; k < 64 && bm.Busy === 1'b1; k++) begin
            busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != 16) begin bad++; $display("FAIL sweep_busy_len got=%0d exp=16", busy_cnt); end
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            bm.Aaddr = 4'(i); bm.Baddr = 4'(i);
            exp_q.push_back(32'(mem[i])); exp_q.push_back(32'(mem[i]));
            #1;
            e = exp_q.pop_front(); total++;
            if (32'(bm.A) !== e) begin bad++; $display("FAIL sweep_after_a got=%h exp=%h", bm.A, e); end
            e = exp_q.pop_front(); total++;
            if (32'(bm.B) !== e) begin bad++; $display("FAIL sweep_after_b got=%h exp=%h", bm.B, e); end
        end
        tick();
    endtask

    task automatic test_clear_mid_sweep;
        bm.Load = 1; bm.Caddr = 4'd12; bm.C = 16'hC0DE;
        tick();
        bm.Load = 0; bm.Sweep = 1;
        tick();
        bm.Sweep = 0;
        tick();
        tick();
        #2 Clear = 1'b1;
        #1;
        total++;
        if (bm.Busy !== 1'b0) begin bad++; $display("FAIL clrsweep_busy got=%b exp=0", bm.Busy); end
        #1 Clear = 1'b0;
        bm.Aaddr = 4'd12;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL clrsweep_r12 got=%h exp=%h", bm.A, e); end
        tick();
        bm.Load = 1; bm.Caddr = 4'd4; bm.C = 16'h4444;
        tick();
        bm.Load = 0;
        total++;
        if (bm.LoadAck !== 1'b1) begin bad++; $display("FAIL clrsweep_idle_ack got=%b exp=1", bm.LoadAck); end
        tick();
    endtask

    task automatic test_bypass;
        bm.Load = 1; bm.Caddr = 4'd9; bm.C = 16'h1111;
        tick();
        bm.C = 16'h5A5A; bm.Aaddr = 4'd9; bm.Baddr = 4'd9;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h5A5A);
`else
        exp_q.push_back(32'h1111);
`endif
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL bypass_same_cycle_a got=%h exp=%h", bm.A, e); end
        tick();
        bm.Load = 0;
        exp_q.push_back(32'h5A5A); exp_q.push_back(32'h5A5A);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bm.A) !== e) begin bad++; $display("FAIL bypass_next_a got=%h exp=%h", bm.A, e); end
        e = exp_q.pop_front(); total++;
        if (32'(bm.B) !== e) begin bad++; $display("FAIL bypass_next_b got=%h exp=%h", bm.B, e); end
        tick();
    endtask

    task automatic test_zero_reg;
        bz.Load = 1; bz.Caddr = 4'd0; bz.C = 16'hFFFF; bz.Aaddr = 4'd0; bz.Baddr = 4'd0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(bz.A) !== e) begin bad++; $display("FAIL zero_same_cycle got=%h exp=%h", bz.A, e); end
        tick();
        bz.Load = 0;
        exp_q.push_back(32'h0);
        #1;
        total++;
        if (bz.LoadAck !== 1'b0) begin bad++; $display("FAIL zero_ack got=%b exp=0", bz.LoadAck); end
        e = exp_q.pop_front(); total++;
        if (32'(bz.A) !== e) begin bad++; $display("FAIL zero_read got=%h exp=%h", bz.A, e); end
        bz.Load = 1; bz.Caddr = 4'd1; bz.C = 16'h1357; bz.Baddr = 4'd1;
        tick();
        bz.Load = 0;
        exp_q.push_back(32'h1357);
        #1;
        total++;
        if (bz.LoadAck !== 1'b1) begin bad++; $display("FAIL zero_r1_ack got=%b exp=1", bz.LoadAck); end
        e = exp_q.pop_front(); total++;
        if (32'(bz.B) !== e) begin bad++; $display("FAIL zero_r1_read got=%h exp=%h", bz.B, e); end
        tick();
    endtask

    task automatic test_params;
        int busy_cnt;
        bw.Load = 1; bw.Caddr = 5'd31; bw.C = 32'hDEADBEEF;
        tick();
        bw.Load = 0; bw.Aaddr = 5'd31;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); total++;
        if (bw.A !== e) begin bad++; $display("FAIL wide_read got=%h exp=%h", bw.A, e); end
        bw.Sweep = 1;
        tick();
        bw.Sweep = 0;
        busy_cnt = 0;
        for (int k = 0; k < 80 && bw.Busy === 1'b1; k++) begin
            busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != 32) begin bad++; $display("FAIL wide_busy_len got=%0d exp=32", busy_cnt); end
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (bw.A !== e) begin bad++; $display("FAIL wide_after_sweep got=%h exp=%h", bw.A, e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_clear_mid_sweep();
        test_bypass();
        test_zero_reg();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
